// File: rtl/mem_subsystem_ctrl.sv
// Memory-subsystem controller: CPU address decode to caches/video/keyboard,
// plus a line-refill FSM that streams cache misses from backing RAM.
module mem_subsystem_ctrl #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned USER_BITS  = 20,
    parameter logic [19:0] VIDEO_BASE = 20'hF0000,
    parameter int unsigned VIDEO_AW   = 11,
    parameter logic [31:0] KEY_ADDR   = 32'hFFFFFFFF
) (
    input  logic                CLK_cpu,
    input  logic                reset,
    input  logic                mem_en,
    input  logic [1:0]          store_size,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         write_data,
    output logic                dcache_read_en,
    output logic                dcache_write_en,
    output logic                video_write_enable,
    output logic [VIDEO_AW-1:0] video_write_addr,
    output logic [7:0]          video_write_data,
    input  logic [7:0]          pressed_key,
    output logic [31:0]         key_data,
    output logic                key_valid,
    output logic                clean_key_buffer,
    input  logic                icache_miss,
    input  logic                dcache_miss,
    input  logic [31:0]         icache_miss_addr,
    input  logic [31:0]         dcache_miss_addr,
    output logic                bus_req,
    output logic [31:0]         bus_addr,
    input  logic                bus_ack,
    input  logic [31:0]         bus_rdata,
    output logic                icache_fetch,
    output logic                dcache_fetch,
    output logic [31:0]         refill_addr,
    output logic [31:0]         refill_data,
    output logic                stall
);

    localparam int unsigned   CW        = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [31:0]   LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
    localparam logic [CW-1:0] LAST      = CW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, DREFILL, IREFILL, DRAIN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          access, is_load, user_hit, video_hit, key_hit;
    logic          vid_store, key_load;
    logic          unused_bits;

    always_comb begin
        access          = (state == IDLE) && mem_en;
        is_load         = (store_size == 2'b11);
        user_hit        = (mem_addr[31:USER_BITS] == '0);
        video_hit       = (mem_addr[31:12] == VIDEO_BASE);
        key_hit         = (mem_addr == KEY_ADDR);
        vid_store       = access && video_hit && (store_size == 2'b00);
        key_load        = access && key_hit && is_load;
        dcache_read_en  = access && user_hit && is_load;
        dcache_write_en = access && user_hit && !is_load;
        stall           = (state != IDLE) || dcache_miss || icache_miss;
        unused_bits     = ^write_data[31:8];
    end

    always_ff @(posedge CLK_cpu) begin
        if (reset) begin
            state              <= IDLE;
            cnt                <= '0;
            bus_req            <= 1'b0;
            bus_addr           <= '0;
            icache_fetch       <= 1'b0;
            dcache_fetch       <= 1'b0;
            refill_addr        <= '0;
            refill_data        <= '0;
            video_write_enable <= 1'b0;
            video_write_addr   <= '0;
            video_write_data   <= '0;
            key_data           <= '0;
            key_valid          <= 1'b0;
            clean_key_buffer   <= 1'b0;
        end else begin
            icache_fetch       <= 1'b0;
            dcache_fetch       <= 1'b0;
            video_write_enable <= vid_store;
            key_valid          <= key_load;
            clean_key_buffer   <= key_load;
            key_data           <= key_load ? {24'b0, pressed_key} : '0;
            if (vid_store) begin
                video_write_addr <= mem_addr[VIDEO_AW-1:0];
                video_write_data <= write_data[7:0];
            end

            // bus_addr doubles as the running word pointer: it starts at the
            // line base and steps by one word per ack.
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (dcache_miss) begin
                        state    <= DREFILL;
                        bus_req  <= 1'b1;
                        bus_addr <= dcache_miss_addr & LINE_MASK;
                    end else if (icache_miss) begin
                        state    <= IREFILL;
                        bus_req  <= 1'b1;
                        bus_addr <= icache_miss_addr & LINE_MASK;
                    end
                end
                DREFILL, IREFILL: begin
                    if (bus_ack) begin
                        dcache_fetch <= (state == DREFILL);
                        icache_fetch <= (state == IREFILL);
                        refill_addr  <= bus_addr;
                        refill_data  <= bus_rdata;
                        bus_addr     <= bus_addr + 32'd4;
                        cnt          <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            state   <= DRAIN;
                            bus_req <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    state    <= IDLE;
                    bus_addr <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_subsystem_ctrl.sv
// Directed self-checking bench for mem_subsystem_ctrl (LINE_WORDS=4).
module tb_mem_subsystem_ctrl;

    localparam int unsigned LW = 4;
    localparam logic [31:0] RKEY = 32'hC0DE0000;

    logic        CLK_cpu = 1'b0;
    logic        reset = 1'b1;
    logic        mem_en = 1'b0;
    logic [1:0]  store_size = 2'b11;
    logic [31:0] mem_addr = '0;
    logic [31:0] write_data = '0;
    logic        dcache_read_en, dcache_write_en;
    logic        video_write_enable;
    logic [10:0] video_write_addr;
    logic [7:0]  video_write_data;
    logic [7:0]  pressed_key = '0;
    logic [31:0] key_data;
    logic        key_valid, clean_key_buffer;
    logic        icache_miss = 1'b0, dcache_miss = 1'b0;
    logic [31:0] icache_miss_addr = '0, dcache_miss_addr = '0;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        icache_fetch, dcache_fetch;
    logic [31:0] refill_addr, refill_data;
    logic        stall;
    logic        ack_en = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Event log for the back-to-back refill test
    logic [31:0] ev_addr [16];
    logic [31:0] ev_data [16];
    logic        ev_is_i [16];
    int unsigned ev_n;

    always #5 CLK_cpu = ~CLK_cpu;

    // Backing RAM model: data is a fixed function of the word address
    assign bus_ack   = bus_req && ack_en;
    assign bus_rdata = bus_addr ^ RKEY;

    mem_subsystem_ctrl #(
        .LINE_WORDS(LW),
        .USER_BITS(20),
        .VIDEO_BASE(20'hF0000),
        .VIDEO_AW(11),
        .KEY_ADDR(32'hFFFFFFFF)
    ) dut (
        .CLK_cpu(CLK_cpu), .reset(reset), .mem_en(mem_en),
        .store_size(store_size), .mem_addr(mem_addr), .write_data(write_data),
        .dcache_read_en(dcache_read_en), .dcache_write_en(dcache_write_en),
        .video_write_enable(video_write_enable), .video_write_addr(video_write_addr),
        .video_write_data(video_write_data), .pressed_key(pressed_key),
        .key_data(key_data), .key_valid(key_valid), .clean_key_buffer(clean_key_buffer),
        .icache_miss(icache_miss), .dcache_miss(dcache_miss),
        .icache_miss_addr(icache_miss_addr), .dcache_miss_addr(dcache_miss_addr),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .icache_fetch(icache_fetch), .dcache_fetch(dcache_fetch),
        .refill_addr(refill_addr), .refill_data(refill_data), .stall(stall)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Model the caches: drop each miss flag once its full line has arrived.
    task automatic watch_refill(input int unsigned budget);
        int unsigned cyc = 0;
        int unsigned dn = 0;
        int unsigned in_cnt = 0;
        ev_n = 0;
        while ((dcache_miss || icache_miss || stall) && cyc < budget) begin
            @(negedge CLK_cpu);
            cyc++;
            ack_en = cyc[0];
            if (dcache_fetch && ev_n < 16) begin
                ev_addr[ev_n] = refill_addr; ev_data[ev_n] = refill_data; ev_is_i[ev_n] = 1'b0;
                ev_n++; dn++;
                if (dn == LW) dcache_miss = 1'b0;
            end
            if (icache_fetch && ev_n < 16) begin
                ev_addr[ev_n] = refill_addr; ev_data[ev_n] = refill_data; ev_is_i[ev_n] = 1'b1;
                ev_n++; in_cnt++;
                if (in_cnt == LW) icache_miss = 1'b0;
            end
        end
        check_eq("watch_in_budget", 32'(cyc < budget), 32'd1);
    endtask

    initial begin
        int unsigned sc;
        logic [31:0] ea;

        repeat (2) @(negedge CLK_cpu);
        check_eq("rst_bus_req", bus_req, 0);
        check_eq("rst_stall", stall, 0);
        check_eq("rst_vwe", video_write_enable, 0);
        check_eq("rst_key_valid", key_valid, 0);
        check_eq("rst_fetch", {30'b0, icache_fetch, dcache_fetch}, 0);
        check_eq("rst_key_data", key_data, 0);
        reset = 1'b0;

        // User-region decode is combinational
        @(negedge CLK_cpu);
        mem_en = 1'b1; store_size = 2'b11; mem_addr = 32'h40; #1;
        check_eq("user_ld_rd", dcache_read_en, 1);
        check_eq("user_ld_wr", dcache_write_en, 0);
        check_eq("user_ld_stall", stall, 0);
        store_size = 2'b10; #1;
        check_eq("user_st_wr", dcache_write_en, 1);
        check_eq("user_st_rd", dcache_read_en, 0);
        mem_addr = 32'h80000000; store_size = 2'b11; #1;
        check_eq("unmapped_rd", dcache_read_en, 0);

        // Video byte store, then dropped word store
        @(negedge CLK_cpu);
        mem_addr = 32'hF0000123; store_size = 2'b00; write_data = 32'h000000A5;
        @(negedge CLK_cpu);
        check_eq("vid_we", video_write_enable, 1);
        check_eq("vid_addr", 32'(video_write_addr), 32'h123);
        check_eq("vid_data", 32'(video_write_data), 32'hA5);
        mem_en = 1'b0;
        @(negedge CLK_cpu);
        check_eq("vid_we_pulse", video_write_enable, 0);
        mem_en = 1'b1; store_size = 2'b10;
        @(negedge CLK_cpu);
        check_eq("vid_word_drop", video_write_enable, 0);
        mem_en = 1'b0;

        // Keyboard read
        @(negedge CLK_cpu);
        pressed_key = 8'h41; mem_addr = 32'hFFFFFFFF; store_size = 2'b11; mem_en = 1'b1;
        @(negedge CLK_cpu);
        check_eq("key_data", key_data, 32'h41);
        check_eq("key_valid", key_valid, 1);
        check_eq("key_clean", clean_key_buffer, 1);
        mem_en = 1'b0;
        @(negedge CLK_cpu);
        check_eq("key_valid_pulse", key_valid, 0);
        check_eq("key_clean_pulse", clean_key_buffer, 0);
        check_eq("key_data_pulse", key_data, 0);
        mem_en = 1'b1; store_size = 2'b10;
        @(negedge CLK_cpu);
        check_eq("key_store_ign", key_valid, 0);
        mem_en = 1'b0;

        // Dcache refill at zero-wait RAM, with a load attempted mid-refill
        @(negedge CLK_cpu);
        ack_en = 1'b1; sc = 0;
        dcache_miss_addr = 32'h0000123C; dcache_miss = 1'b1;
        mem_en = 1'b1; mem_addr = 32'h40; store_size = 2'b11; #1;
        if (stall) sc++;
        check_eq("dm_req_latch", bus_req, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK_cpu);
            if (stall) sc++;
            check_eq("dm_bus_req", bus_req, 1);
            check_eq("dm_bus_addr", bus_addr, 32'h1230 + 32'(4 * k));
            check_eq("dm_fetch", dcache_fetch, 32'(k > 0));
            check_eq("dm_no_decode", dcache_read_en, 0);
            if (k > 0) begin
                ea = 32'h1230 + 32'(4 * (k - 1));
                check_eq("dm_refill_addr", refill_addr, ea);
                check_eq("dm_refill_data", refill_data, ea ^ RKEY);
            end
        end
        mem_en = 1'b0;
        @(negedge CLK_cpu);
        if (stall) sc++;
        check_eq("dm_drain_req", bus_req, 0);
        check_eq("dm_last_fetch", dcache_fetch, 1);
        check_eq("dm_last_addr", refill_addr, 32'h123C);
        check_eq("dm_last_data", refill_data, 32'h123C ^ RKEY);
        dcache_miss = 1'b0;
        @(negedge CLK_cpu);
        if (stall) sc++;
        check_eq("dm_idle_stall", stall, 0);
        check_eq("dm_stall_cycles", sc, 6);

        // Simultaneous misses, RAM with wait states: dcache line first
        @(negedge CLK_cpu);
        dcache_miss_addr = 32'h00002008; icache_miss_addr = 32'h00003FFC;
        dcache_miss = 1'b1; icache_miss = 1'b1;
        watch_refill(200);
        check_eq("both_ev_count", ev_n, 8);
        for (int k = 0; k < 8; k++) begin
            ea = (k < 4) ? 32'h2000 + 32'(4 * k) : 32'h3FF0 + 32'(4 * (k - 4));
            check_eq("both_order", ev_is_i[k], 32'(k >= 4));
            check_eq("both_addr", ev_addr[k], ea);
            check_eq("both_data", ev_data[k], ea ^ RKEY);
        end

        // Reset after the second ack aborts the refill
        @(negedge CLK_cpu);
        ack_en = 1'b1;
        dcache_miss_addr = 32'h00000508; dcache_miss = 1'b1;
        repeat (3) @(negedge CLK_cpu);
        check_eq("rr_second_fetch", refill_addr, 32'h504);
        reset = 1'b1;
        @(negedge CLK_cpu);
        check_eq("rr_bus_req", bus_req, 0);
        check_eq("rr_fetch", dcache_fetch, 0);
        check_eq("rr_stall_miss", stall, 1);
        reset = 1'b0; dcache_miss = 1'b0;
        @(negedge CLK_cpu);
        check_eq("rr_stall_idle", stall, 0);
        check_eq("rr_no_fetch", dcache_fetch, 0);
        check_eq("rr_idle_req", bus_req, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_subsystem_ctrl.md
# mem_subsystem_ctrl

Parametrised memory-subsystem controller between the CPU core, the L1 instruction/data caches, the backing RAM port, and the memory-mapped video and keyboard devices. Each CPU access is decoded by address region into a cache read/write enable, a video write, or a keyboard read. Instruction- and data-cache misses are serviced through a refill state machine that streams `LINE_WORDS` words from backing RAM. `stall` is held while any refill is in progress.

## Interface

Parameters:
- `LINE_WORDS`, 4: words per cache line refill; power of two, 1..16
- `USER_BITS`, 20: user memory spans `0` .. `2^USER_BITS-1`; region hit when `mem_addr[31:USER_BITS]==0`
- `VIDEO_BASE`, 20'hF0000: video region hit when `mem_addr[31:12]==VIDEO_BASE`
- `VIDEO_AW`, 11: video address width
- `KEY_ADDR`, 32'hFFFFFFFF: keyboard register address

Ports:
- `CLK_cpu`  in  1  clock; the only clock. All logic is sampled on its rising edge.
- `reset`  in  1  reset; synchronous, active-high.
- `mem_en`  in  1  CPU load/store valid.
- `store_size`  in  2  `11`=load; `00`/`01`/`10`=store of byte/half/word.
- `mem_addr`  in  32  CPU data address.
- `write_data`  in  32  store data.
- `dcache_read_en`, `dcache_write_en`  out  1  data-cache access enables.
- `video_write_enable`  out  1  registered video write strobe.
- `video_write_addr`  out  VIDEO_AW  registered `mem_addr[VIDEO_AW-1:0]`.
- `video_write_data`  out  8  registered `write_data[7:0]`.
- `pressed_key`  in  8  keyboard buffer.
- `key_data`  out  32  registered, zero-extended `pressed_key`.
- `key_valid`  out  1  `key_data` valid (1 cycle).
- `clean_key_buffer`  out  1  1-cycle pulse clearing the keyboard buffer.
- `icache_miss`, `dcache_miss`  in  1  miss flags; held until the matching fetch completes.
- `icache_miss_addr`, `dcache_miss_addr`  in  32  miss addresses.
- `bus_req`  out  1  backing-RAM read request.
- `bus_addr`  out  32  word address of the requested word.
- `bus_ack`  in  1  `bus_rdata` valid for the current `bus_addr`.
- `bus_rdata`  in  32  RAM read data.
- `icache_fetch`, `dcache_fetch`  out  1  refill write strobe to the named cache.
- `refill_addr`  out  32  line address plus word offset for the current fetch strobe.
- `refill_data`  out  32  refill word.
- `stall`  out  1  CPU pipeline hold.

## Operation

Address decode applies while `mem_en=1` and the FSM is in IDLE:
- User region: load sets `dcache_read_en`; store sets `dcache_write_en`.
- Video region: a byte store (`00`) pulses `video_write_enable` for one cycle. Half and word stores to video are dropped. Loads from video return no data and raise no strobe.
- `KEY_ADDR` load: `key_data`/`key_valid` are registered next cycle, and `clean_key_buffer` pulses in that same cycle. Stores to `KEY_ADDR` are ignored.
- Unmapped addresses: no strobes; the access completes silently.

Refill FSM states are IDLE, DREFILL, IREFILL, DRAIN.
- IDLE: if `dcache_miss` → DREFILL; else if `icache_miss` → IREFILL. When both are set, dcache wins. The line base (miss address with the low `log2(LINE_WORDS)+2` bits cleared) is latched, and the word counter is cleared.
- DREFILL/IREFILL: `bus_req=1`, `bus_addr=base+4*cnt`. On each `bus_ack`, assert the matching `*_fetch` for one cycle with `refill_data=bus_rdata`, `refill_addr=bus_addr`, then increment `cnt`. The ack for the last word (`cnt==LINE_WORDS-1`) → DRAIN.
- DRAIN: one cycle with no request, so the cache can clear its miss flag; then → IDLE. A pending other-side miss is taken from IDLE on the following cycle.

Rules:
- `stall` = (state != IDLE) OR (in IDLE, either miss flag set).
- No decode strobes fire outside IDLE.
- The counter is `$clog2(LINE_WORDS)` bits wide (min 1). Addresses wrap modulo 2^32.
- `reset` mid-refill aborts immediately: the FSM goes to IDLE and partial line data stays in the cache. The cache must re-raise its miss.

## Timing

- Reset values: every output is 0, the FSM is IDLE, and `cnt`=0.
- Decode enables (`dcache_*_en`) are combinational from the inputs in IDLE. Video/keyboard outputs are registered (1-cycle latency).
- Refill: `bus_req` rises the cycle after the miss is seen in IDLE. Each `*_fetch` coincides with the cycle after its `bus_ack` (registered). `bus_ack` may arrive back-to-back or with any number of wait cycles.
- Minimum miss-to-IDLE time is `LINE_WORDS+2` cycles at zero-wait RAM: one latch cycle, `LINE_WORDS` data cycles, one DRAIN cycle.
- `bus_ack` outside DREFILL/IREFILL is ignored.

## Test plan

- Reset, then a load at `0x00000040` with `mem_en=1` → `dcache_read_en=1` the same cycle, `stall=0`, all other strobes 0.
- Byte store of `0x000000A5` to `0xF0000123` → the next cycle `video_write_enable=1`, `video_write_addr=0x123`, `video_write_data=0xA5`. A word store to the same address produces no strobe.
- `pressed_key=0x41`, load `0xFFFFFFFF` → the next cycle `key_data=0x00000041`, `key_valid=1`, `clean_key_buffer=1`, each for exactly one cycle.
- `dcache_miss` at `0x0000123C`, `LINE_WORDS=4`, zero-wait RAM → `bus_addr` 0x1230, 0x1234, 0x1238, 0x123C. Four `dcache_fetch` pulses carry the matching data. `stall` is high for 6 cycles.
- Simultaneous I/D misses → the dcache line is refilled fully, then DRAIN, then the icache refill. No `icache_fetch` occurs during DREFILL.
- `reset` asserted after the 2nd ack of a refill → the next cycle FSM is IDLE, `bus_req=0`, `stall` follows the miss flags, and no further fetch strobes occur.
